// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising CPU and loader accesses onto one memory port.
// The loader can lock the CPU out while it writes a new program image.
module mem_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adrs,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_adrs,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    output logic [DW-1:0] ld_rdata,
    input  logic          ld_lock,
    output logic [AW-1:0] mem_adrs,
    output logic [DW-1:0] mem_data,
    output logic          mem_wr_en,
    input  logic [DW-1:0] mem_q,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t        r_state;
    logic          r_last_ld;
    logic          r_win_ld;
    logic          r_we;
    logic [AW-1:0] r_adrs;
    logic [DW-1:0] r_data;
    logic          r_wr_en;
    logic          r_cpu_ack;
    logic          r_ld_ack;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_ld_rdata;

    logic w_cpu_elig;
    logic w_ld_elig;
    logic w_any;
    logic w_pick_ld;

    assign w_cpu_elig = cpu_req & ~ld_lock;
    assign w_ld_elig  = ld_req;
    assign w_any      = w_cpu_elig | w_ld_elig;
    // On a tie the port that did not win last time takes the grant.
    assign w_pick_ld  = w_ld_elig & (~w_cpu_elig | ~r_last_ld);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_last_ld   <= 1'b1;
            r_win_ld    <= 1'b0;
            r_we        <= 1'b0;
            r_adrs      <= '0;
            r_data      <= '0;
            r_wr_en     <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_ld_ack    <= 1'b0;
            r_cpu_rdata <= '0;
            r_ld_rdata  <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_ld_ack  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_win_ld  <= w_pick_ld;
                        r_last_ld <= w_pick_ld;
                        r_we      <= w_pick_ld ? ld_we : cpu_we;
                        r_wr_en   <= w_pick_ld ? ld_we : cpu_we;
                        r_adrs    <= w_pick_ld ? ld_adrs : cpu_adrs;
                        r_data    <= w_pick_ld ? ld_wdata : cpu_wdata;
                        r_state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_wr_en <= 1'b0;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (r_win_ld) begin
                        r_ld_ack <= 1'b1;
                        if (!r_we) r_ld_rdata <= mem_q;
                    end else begin
                        r_cpu_ack <= 1'b1;
                        if (!r_we) r_cpu_rdata <= mem_q;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign ld_ack    = r_ld_ack;
    assign ld_rdata  = r_ld_rdata;
    assign mem_adrs  = r_adrs;
    assign mem_data  = r_data;
    assign mem_wr_en = r_wr_en;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a
// transaction-level model: grant order, 3-cycle latency, shadow memory.
module tb_mem_port_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_adrs = '0, cpu_wdata = '0;
    logic       ld_req = 1'b0, ld_we = 1'b0, ld_lock = 1'b0;
    logic [7:0] ld_adrs = '0, ld_wdata = '0;
    logic       cpu_ack, ld_ack, mem_wr_en, busy;
    logic [7:0] cpu_rdata, ld_rdata, mem_adrs, mem_data;
    logic [7:0] mem_q = '0;

    logic [7:0] ram [256];
    logic [7:0] ref_mem [256];

    always #5 clock = ~clock;

    mem_port_arbiter #(.AW(8), .DW(8)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adrs(cpu_adrs),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_adrs(ld_adrs),
        .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .ld_lock(ld_lock),
        .mem_adrs(mem_adrs), .mem_data(mem_data), .mem_wr_en(mem_wr_en),
        .mem_q(mem_q), .busy(busy)
    );

    // Synchronous-read memory
    always @(posedge clock) begin
        if (mem_wr_en) ram[mem_adrs] <= mem_data;
        mem_q <= ram[mem_adrs];
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transaction-level model: one op in flight, granted at m_t0,
    // acked after edge m_t0+2, next arbitration at edge m_t0+3.
    int         cyc = 0;
    bit         m_act, m_port, m_last, m_we;
    int         m_t0;
    logic [7:0] m_adrs, m_wd;
    logic       e_cack, e_lack, e_wr, e_busy;
    logic [7:0] e_adrs, e_data, e_crd, e_lrd;

    task automatic model_reset();
        m_act = 0; m_last = 1;
        e_cack = 0; e_lack = 0; e_wr = 0; e_busy = 0;
        e_adrs = 0; e_data = 0; e_crd = 0; e_lrd = 0;
    endtask

    task automatic model_edge();
        bit c_el, l_el;
        e_cack = 0; e_lack = 0; e_wr = 0;
        if (m_act && cyc == m_t0 + 2) begin
            if (m_we) ref_mem[m_adrs] = m_wd;
            else if (m_port) e_lrd = ref_mem[m_adrs];
            else e_crd = ref_mem[m_adrs];
            if (m_port) e_lack = 1; else e_cack = 1;
        end
        if (m_act && cyc == m_t0 + 3) m_act = 0;
        if (!m_act) begin
            c_el = cpu_req && !ld_lock;
            l_el = ld_req;
            if (c_el || l_el) begin
                m_port = (c_el && l_el) ? !m_last : l_el;
                m_last = m_port;
                m_act = 1; m_t0 = cyc;
                m_we   = m_port ? ld_we : cpu_we;
                m_adrs = m_port ? ld_adrs : cpu_adrs;
                m_wd   = m_port ? ld_wdata : cpu_wdata;
                e_adrs = m_adrs; e_data = m_wd; e_wr = m_we;
            end
        end
        e_busy = m_act && (cyc < m_t0 + 2);
    endtask

    task automatic compare();
        chk("cpu_ack", cpu_ack, e_cack);
        chk("ld_ack", ld_ack, e_lack);
        chk("cpu_rdata", cpu_rdata, e_crd);
        chk("ld_rdata", ld_rdata, e_lrd);
        chk("mem_wr_en", mem_wr_en, e_wr);
        chk("mem_adrs", mem_adrs, e_adrs);
        chk("mem_data", mem_data, e_data);
        chk("busy", busy, e_busy);
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        model_edge();
        #1;
        compare();
    endtask

    task automatic do_reset();
        reset = 1; cpu_req = 0; ld_req = 0; ld_lock = 0;
        model_reset();
        #1;
        compare();
        @(negedge clock);
        reset = 0;
    endtask

    function automatic logic [7:0] radr();
        case ($urandom_range(3))
            0: return 8'h00;
            1: return 8'hFF;
            default: return 8'($urandom_range(15));
        endcase
    endfunction

    task automatic cpu_op(input logic we, input logic [7:0] a, input logic [7:0] d);
        cpu_req = 1; cpu_we = we; cpu_adrs = a; cpu_wdata = d;
    endtask

    task automatic ld_op(input logic we, input logic [7:0] a, input logic [7:0] d);
        ld_req = 1; ld_we = we; ld_adrs = a; ld_wdata = d;
    endtask

    task automatic wait_ack(input bit ld, output int n);
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if ((ld ? ld_ack : cpu_ack) === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk("ack_timeout", 0, 1);
    endtask

    initial begin
        int n, wr_cnt, nld, ncpu, first_after, nla;
        logic [7:0] wa, wd, a6, d6;
        int order[$];

        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[7] = 8'h03; ref_mem[7] = 8'h03;
        model_reset();
        @(negedge clock);
        do_reset();

        // T1: lone CPU read
        cpu_op(0, 8'h07, 8'h00);
        wait_ack(0, n);
        chk("t1_latency", n, 3);
        chk("t1_rdata", cpu_rdata, 8'h03);
        chk("t1_ld_ack", ld_ack, 0);
        cpu_req = 0;
        tick();

        // T2: loader write A5 to FF, then CPU read back
        ld_op(1, 8'hFF, 8'hA5);
        wr_cnt = 0; wa = 0; wd = 0; n = 0;
        for (int i = 1; i <= 12 && n == 0; i++) begin
            tick();
            if (mem_wr_en) begin wr_cnt++; wa = mem_adrs; wd = mem_data; end
            if (ld_ack) n = i;
        end
        ld_req = 0;
        chk("t2_wr_cnt", wr_cnt, 1);
        chk("t2_wr_adrs", wa, 8'hFF);
        chk("t2_wr_data", wd, 8'hA5);
        cpu_op(0, 8'hFF, 8'h00);
        wait_ack(0, n);
        chk("t2_readback", cpu_rdata, 8'hA5);
        cpu_req = 0;
        tick();

        // T3: both held -> strict alternation starting with CPU
        do_reset();
        cpu_op(0, 8'h07, 8'h00);
        ld_op(0, 8'hFF, 8'h00);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cpu_ack) order.push_back(0);
            if (ld_ack) order.push_back(1);
        end
        cpu_req = 0; ld_req = 0;
        chk("t3_nacks", order.size(), 4);
        for (int i = 0; i < order.size(); i++) chk("t3_order", order[i], i % 2);
        tick(); tick();

        // T4: lock keeps CPU out for 4 loader writes, then CPU next
        ld_lock = 1;
        cpu_op(0, 8'h07, 8'h00);
        ld_op(1, radr(), 8'($urandom));
        nld = 0; ncpu = 0; first_after = -1;
        for (int i = 0; i < 40 && first_after < 0; i++) begin
            tick();
            if (cpu_ack) begin
                if (nld >= 4) first_after = 0; else ncpu++;
            end
            if (ld_ack) begin
                if (nld >= 4) first_after = 1;
                nld++;
                if (nld == 4) ld_lock = 0;
                ld_op(1, radr(), 8'($urandom));
            end
        end
        cpu_req = 0; ld_req = 0; ld_lock = 0;
        chk("t4_cpu_locked", ncpu, 0);
        chk("t4_cpu_next", first_after, 0);
        tick(); tick(); tick();

        // T5: lock raised while CPU access is in flight
        cpu_op(0, 8'h07, 8'h00);
        tick();
        ld_lock = 1;
        ld_op(0, 8'h07, 8'h00);
        wait_ack(0, n);
        chk("t5_cpu_acked", n, 2);
        ncpu = 0; nla = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (cpu_ack) ncpu++;
            if (ld_ack) nla++;
        end
        chk("t5_cpu_after_lock", ncpu, 0);
        chk("t5_ld_acks", nla, 3);
        cpu_req = 0; ld_req = 0; ld_lock = 0;
        tick(); tick(); tick();

        // T6: reset during ACCESS of a write
        a6 = 8'h20;
        d6 = ~ref_mem[a6];
        cpu_op(1, a6, d6);
        tick();
        chk("t6_wr_pending", mem_wr_en, 1);
        #2;
        do_reset();
        chk("t6_busy", busy, 0);
        chk("t6_wr_en", mem_wr_en, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("t6_no_write", ram[a6], ref_mem[a6]);

        // Random traffic
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (cpu_ack) begin
                if ($urandom_range(99) < 50) cpu_op(1'($urandom), radr(), 8'($urandom));
                else cpu_req = 0;
            end else if (!cpu_req && $urandom_range(99) < 35)
                cpu_op(1'($urandom), radr(), 8'($urandom));
            if (ld_ack) begin
                if ($urandom_range(99) < 50) ld_op(1'($urandom), radr(), 8'($urandom));
                else ld_req = 0;
            end else if (!ld_req && $urandom_range(99) < 35)
                ld_op(1'($urandom), radr(), 8'($urandom));
            if ($urandom_range(99) < 4) ld_lock = ~ld_lock;
        end
        cpu_req = 0; ld_req = 0; ld_lock = 0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 16; i++) chk("final_mem", ram[i], ref_mem[i]);
        chk("final_mem_ff", ram[255], ref_mem[255]);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
